// File: rtl/gpu_cmd_engine.sv
// gpu_cmd_engine: polls the coprocessor command register and runs FILL/FLIP.
// Optional `GPU_IRQ_EN adds an interrupt write (reg 2 = 1) after the ack.
module gpu_cmd_engine #(
  parameter int POLL_GAP = 16,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  output logic [19:0] creg_addr,
  output logic [47:0] creg_wdata,
  input  logic [47:0] creg_rdata,
  output logic        creg_sel,
  output logic        creg_we,
  input  logic        creg_ready,
  output logic [19:0] fb_addr,
  output logic [47:0] fb_wdata,
  output logic        fb_sel,
  input  logic        fb_ready,
  output logic        busy,
  output logic [15:0] cmd_done
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [19:0] REG_VGA = 20'd0;
  localparam logic [19:0] REG_IRQ = 20'd2;
  localparam logic [19:0] REG_CMD = 20'd3;

  localparam logic [3:0] OP_FILL = 4'd1;
  localparam logic [3:0] OP_FLIP = 4'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_WAIT,
    S_DECODE,
    S_FILL,
    S_FLIP,
    S_ACK,
    S_IRQ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [47:0]      cmd_q, cmd_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [19:0] creg_addr_q, creg_addr_d;
  logic [47:0] creg_wdata_q, creg_wdata_d;
  logic        creg_sel_q, creg_sel_d;
  logic        creg_we_q, creg_we_d;
  logic [19:0] fb_addr_q, fb_addr_d;
  logic [47:0] fb_wdata_q, fb_wdata_d;
  logic        fb_sel_q, fb_sel_d;
  logic        busy_q, busy_d;
  logic [15:0] cmd_done_q, cmd_done_d;

  logic [3:0]       cmd_op;
  logic [19:0]      cmd_a;
  logic [CNT_W-1:0] cmd_n;
  logic [11:0]      cmd_c;
  logic             is_fill;
  logic             is_flip;
  logic             creg_xfer;
  logic             fb_xfer;

  assign cmd_op = cmd_q[47:44];
  assign cmd_a  = cmd_q[43:24];
  assign cmd_n  = cmd_q[12 +: CNT_W];
  assign cmd_c  = cmd_q[11:0];

  // A zero-length FILL degenerates to a plain ack.
  assign is_fill = (cmd_op == OP_FILL) && (cmd_n != '0);
  assign is_flip = (cmd_op == OP_FLIP);

  // Ready only counts while our own request is up.
  assign creg_xfer = creg_sel_q & creg_ready;
  assign fb_xfer   = fb_sel_q & fb_ready;

  // Next-state and next-output logic; every request is set up one edge early
  // so that bus outputs come straight from flops.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    creg_addr_d  = creg_addr_q;
    creg_wdata_d = creg_wdata_q;
    creg_sel_d   = creg_sel_q;
    creg_we_d    = creg_we_q;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    fb_sel_d     = fb_sel_q;
    busy_d       = busy_q;
    cmd_done_d   = cmd_done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        creg_sel_d   = 1'b1;
        creg_we_d    = 1'b0;
        creg_addr_d  = REG_CMD;
        creg_wdata_d = '0;
        state_d      = S_POLL;
      end

      S_POLL: begin
        if (creg_xfer) begin
          creg_sel_d = 1'b0;
          if (creg_rdata != '0) begin
            cmd_d   = creg_rdata;
            busy_d  = 1'b1;
            state_d = S_DECODE;
          end else begin
            gap_d   = GAP_W'(POLL_GAP - 1);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (gap_q == '0) begin
          creg_sel_d   = 1'b1;
          creg_we_d    = 1'b0;
          creg_addr_d  = REG_CMD;
          creg_wdata_d = '0;
          state_d      = S_POLL;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DECODE: begin
        unique case (1'b1)
          is_fill: begin
            fb_sel_d   = 1'b1;
            fb_addr_d  = cmd_a;
            fb_wdata_d = {4{cmd_c}};
            rem_d      = cmd_n;
            state_d    = S_FILL;
          end
          is_flip: begin
            creg_sel_d   = 1'b1;
            creg_we_d    = 1'b1;
            creg_addr_d  = REG_VGA;
            creg_wdata_d = {28'b0, cmd_a};
            state_d      = S_FLIP;
          end
          default: begin
            creg_sel_d   = 1'b1;
            creg_we_d    = 1'b1;
            creg_addr_d  = REG_CMD;
            creg_wdata_d = '0;
            state_d      = S_ACK;
          end
        endcase
      end

      S_FILL: begin
        if (fb_xfer) begin
          if (rem_q == CNT_W'(1)) begin
            fb_sel_d     = 1'b0;
            creg_sel_d   = 1'b1;
            creg_we_d    = 1'b1;
            creg_addr_d  = REG_CMD;
            creg_wdata_d = '0;
            state_d      = S_ACK;
          end else begin
            rem_d     = rem_q - CNT_W'(1);
            fb_addr_d = fb_addr_q + 20'd1;
          end
        end
      end

      S_FLIP: begin
        if (creg_xfer) begin
          creg_sel_d   = 1'b1;
          creg_we_d    = 1'b1;
          creg_addr_d  = REG_CMD;
          creg_wdata_d = '0;
          state_d      = S_ACK;
        end
      end

      S_ACK: begin
        if (creg_xfer) begin
`ifdef GPU_IRQ_EN
          creg_sel_d   = 1'b1;
          creg_we_d    = 1'b1;
          creg_addr_d  = REG_IRQ;
          creg_wdata_d = 48'h1;
          state_d      = S_IRQ;
`else
          creg_sel_d = 1'b0;
          creg_we_d  = 1'b0;
          busy_d     = 1'b0;
          cmd_done_d = cmd_done_q + 16'd1;
          state_d    = S_DONE;
`endif
        end
      end

      S_IRQ: begin
        if (creg_xfer) begin
          creg_sel_d = 1'b0;
          creg_we_d  = 1'b0;
          busy_d     = 1'b0;
          cmd_done_d = cmd_done_q + 16'd1;
          state_d    = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and aborts any
  // in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      rem_q        <= '0;
      gap_q        <= '0;
      creg_addr_q  <= '0;
      creg_wdata_q <= '0;
      creg_sel_q   <= 1'b0;
      creg_we_q    <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      fb_sel_q     <= 1'b0;
      busy_q       <= 1'b0;
      cmd_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      creg_addr_q  <= creg_addr_d;
      creg_wdata_q <= creg_wdata_d;
      creg_sel_q   <= creg_sel_d;
      creg_we_q    <= creg_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_sel_q     <= fb_sel_d;
      busy_q       <= busy_d;
      cmd_done_q   <= cmd_done_d;
    end
  end

  assign creg_addr  = creg_addr_q;
  assign creg_wdata = creg_wdata_q;
  assign creg_sel   = creg_sel_q;
  assign creg_we    = creg_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign fb_sel     = fb_sel_q;
  assign busy       = busy_q;
  assign cmd_done   = cmd_done_q;

endmodule
